// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-size encodings, Nk/Nr constants and Rcon table
// Purpose: common AES definitions used by the key schedule.
// Ports: none (package).
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128     = 2'b00,
    KL_192     = 2'b01,
    KL_256     = 2'b10,
    KL_ILLEGAL = 2'b11
  } key_len_e;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Rcon[1..10]; Rcon[1] sits in the top byte.
  localparam logic [79:0] RCON_TBL = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  function automatic logic [7:0] rcon(input logic [3:0] j);
    if (j == 4'd0 || j > 4'd10) return 8'h00;
    return RCON_TBL[8*(10-int'(j)) +: 8];
  endfunction

endpackage

// File: rtl/key_schedule_if.sv
// rtl/key_schedule_if.sv - request and round-key handshake bundle of the key schedule
// Purpose: groups the start request and round-key stream signals.
// Ports (signals): start, key_len[1:0], key_in[255:0], rk_ready toward the
//   schedule; round_key[127:0], rk_valid, rk_index[3:0], busy, done, err from it.
// Modports: master (requester/consumer), slave (key schedule).
interface key_schedule_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         rk_ready;
  logic [127:0] round_key;
  logic         rk_valid;
  logic [3:0]   rk_index;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output start, key_len, key_in, rk_ready,
    input  round_key, rk_valid, rk_index, busy, done, err
  );

  modport slave (
    input  start, key_len, key_in, rk_ready,
    output round_key, rk_valid, rk_index, busy, done, err
  );
endinterface

// File: rtl/key_schedule_sub_word.sv
// rtl/key_schedule_sub_word.sv - four parallel combinational AES S-boxes (SubWord)
// Purpose: byte-wise AES S-box substitution of a 32-bit word.
// Ports: i_word[31:0] in, o_word[31:0] out.
module sub_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  // Entry 0 occupies the top byte, so entry x lives at bit offset (255-x)*8.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                   sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - AES-128/192/256 key expansion streaming one round key per 4 words
// Purpose: expands a latched cipher key one word per cycle into round keys
//   delivered over a valid/ready handshake.
// Ports: clk, rst (sync, active-high); bus (key_schedule_if.slave): start,
//   key_len, key_in, rk_ready in; round_key, rk_valid, rk_index, busy, done, err out.
// Build option: KEY_SCHEDULE_AES192_EN enables key_len=01 (AES-192).
module key_schedule
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  key_schedule_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e       r_state;
  key_len_e     r_len;
  logic [255:0] r_key;          // shifts left one word per key word consumed
  logic [31:0]  r_win [8];      // r_win[k] = w[i-1-k]
  logic [31:0]  r_stage [4];
  logic [2:0]   r_cnt;          // words in staging, 0..4
  logic [5:0]   r_idx;          // index i of the next word
  logic [2:0]   r_mod;          // i mod Nk
  logic [3:0]   r_rc;           // i / Nk
  logic [3:0]   r_next_rk;
  logic [127:0] r_round_key;
  logic         r_rk_valid;
  logic [3:0]   r_rk_index;
  logic         r_done;
  logic         r_err;

  logic [3:0]   w_nk;
  logic [3:0]   w_nr;
  logic [5:0]   w_total;
  logic         w_len_ok;
  logic [31:0]  w_sw_in;
  logic [31:0]  w_sw_out;
  logic [31:0]  w_t;
  logic [31:0]  w_word;
  logic         w_full;
  logic         w_can_move;
  logic         w_move;
  logic         w_gen;
  logic         w_hs;

  always_comb begin
    w_nk = NK_256;
    w_nr = NR_256;
    case (r_len)
      KL_128: begin
        w_nk = NK_128;
        w_nr = NR_128;
      end
`ifdef KEY_SCHEDULE_AES192_EN
      KL_192: begin
        w_nk = NK_192;
        w_nr = NR_192;
      end
`endif
      default: ;
    endcase
  end

`ifdef KEY_SCHEDULE_AES192_EN
  assign w_len_ok = (bus.key_len != KL_ILLEGAL);
`else
  assign w_len_ok = (bus.key_len == KL_128) || (bus.key_len == KL_256);
`endif

  assign w_total = {w_nr + 4'd1, 2'b00};

  // RotWord only on the Nk boundary; the Nk=8 mid-point uses plain SubWord.
  assign w_sw_in = (r_mod == 3'd0) ? {r_win[0][23:0], r_win[0][31:24]} : r_win[0];

  sub_word u_sub_word (
    .i_word (w_sw_in),
    .o_word (w_sw_out)
  );

  always_comb begin
    if (r_mod == 3'd0)
      w_t = w_sw_out ^ {rcon(r_rc), 24'h0};
    else if (w_nk == 4'd8 && r_mod == 3'd4)
      w_t = w_sw_out;
    else
      w_t = r_win[0];
  end

  assign w_word = (r_idx < {2'b00, w_nk}) ? r_key[255:224]
                                          : (r_win[3'(w_nk - 4'd1)] ^ w_t);

  assign w_full     = (r_cnt == 3'd4);
  assign w_can_move = !r_rk_valid || bus.rk_ready;
  assign w_move     = (r_state == ST_RUN) && w_full && w_can_move;
  assign w_gen      = (r_state == ST_RUN) && (r_idx != w_total) && (!w_full || w_can_move);
  assign w_hs       = r_rk_valid && bus.rk_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_len       <= KL_128;
      r_key       <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_mod       <= '0;
      r_rc        <= '0;
      r_next_rk   <= '0;
      r_round_key <= '0;
      r_rk_valid  <= 1'b0;
      r_rk_index  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      for (int k = 0; k < 8; k++) r_win[k] <= '0;
      for (int k = 0; k < 4; k++) r_stage[k] <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (w_len_ok) begin
              r_state   <= ST_RUN;
              r_key     <= bus.key_in;
              r_len     <= key_len_e'(bus.key_len);
              r_cnt     <= '0;
              r_idx     <= '0;
              r_mod     <= '0;
              r_rc      <= '0;
              r_next_rk <= '0;
              for (int k = 0; k < 8; k++) r_win[k] <= '0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_gen) begin
            r_key    <= {r_key[223:0], 32'h0};
            r_win[0] <= w_word;
            for (int k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
            r_idx    <= r_idx + 6'd1;
            if (r_mod == 3'(w_nk - 4'd1)) begin
              r_mod <= '0;
              r_rc  <= r_rc + 4'd1;
            end else begin
              r_mod <= r_mod + 3'd1;
            end
          end
          if (w_move) begin
            // Staging drains while the next word lands in slot 0 in the same cycle.
            r_round_key <= {r_stage[0], r_stage[1], r_stage[2], r_stage[3]};
            r_rk_valid  <= 1'b1;
            r_rk_index  <= r_next_rk;
            r_next_rk   <= r_next_rk + 4'd1;
            if (w_gen) begin
              r_stage[0] <= w_word;
              r_cnt      <= 3'd1;
            end else begin
              r_cnt      <= 3'd0;
            end
          end else begin
            if (w_gen) begin
              r_stage[r_cnt[1:0]] <= w_word;
              r_cnt               <= r_cnt + 3'd1;
            end
            if (w_hs) begin
              r_rk_valid <= 1'b0;
              if (r_rk_index == w_nr) begin
                r_state <= ST_IDLE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.round_key = r_round_key;
  assign bus.rk_valid  = r_rk_valid;
  assign bus.rk_index  = r_rk_index;
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_key_schedule.sv
// tb/tb_key_schedule.sv - directed self-checking bench for key_schedule
// Purpose: FIPS-197 vectors, latency, backpressure, reset and start interference.
// Ports: none (top-level bench).
`timescale 1ns/1ps
module tb_key_schedule;

  localparam logic [255:0] K128   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] R128_1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R128_3 = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] R128_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256_E = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [255:0] K192   = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [127:0] R192_C = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] KJUNK  = {8{32'hdeadbeef}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_schedule_if bus();

  key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] rk_seen [15];
  int rk_cyc [15];
  int hs;
  int dn;
  int lat;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consume round keys until done, optionally stalling 7 cycles at one round
  // and optionally pulsing start mid-run.
  task automatic collect(input int stall_at, input bit poke);
    int post;
    bit stalled;
    bit stable;
    logic [127:0] hold;
    hs = 0; dn = 0; post = 0; stalled = 1'b0;
    for (int r = 0; r < 15; r++) begin rk_seen[r] = '0; rk_cyc[r] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (bus.done) dn++;
      if (dn > 0) post++;
      if (post > 3) break;
      if (stall_at >= 0 && !stalled && bus.rk_valid && int'(bus.rk_index) == stall_at) begin
        hold = bus.round_key;
        stable = 1'b1;
        bus.rk_ready = 1'b0;
        repeat (7) begin
          tick();
          if (bus.round_key !== hold || int'(bus.rk_index) != stall_at || bus.rk_valid !== 1'b1)
            stable = 1'b0;
        end
        bus.rk_ready = 1'b1;
        stalled = 1'b1;
        check("bp_stable", 128'(stable), 128'd1);
      end
      bus.start  = poke && (cyc == 10);
      if (poke && cyc == 10) begin
        bus.key_in  = KJUNK;
        bus.key_len = 2'b00;
      end
      if (bus.rk_valid && bus.rk_ready) begin
        rk_seen[int'(bus.rk_index)] = bus.round_key;
        rk_cyc[int'(bus.rk_index)]  = cyc;
        hs++;
      end
      tick();
    end
    bus.start = 1'b0;
  endtask

  task automatic run(input logic [1:0] len, input logic [255:0] key,
                     input int stall_at, input bit poke);
    bus.key_len = len;
    bus.key_in  = key;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    check("busy_after_start", 128'(bus.busy), 128'd1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.rk_valid) begin
        lat = k;
        break;
      end
    end
    collect(stall_at, poke);
  endtask

  task automatic reject(input string tag, input logic [1:0] len);
    bus.key_len = len;
    bus.key_in  = K128;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    check({tag, "_err"},  128'(bus.err),  128'd1);
    check({tag, "_busy"}, 128'(bus.busy), 128'd0);
    tick();
    check({tag, "_err_pulse"}, 128'(bus.err), 128'd0);
    check({tag, "_busy2"}, 128'(bus.busy), 128'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.key_len = 2'b00; bus.key_in = '0; bus.rk_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    check("rst_round_key", bus.round_key, 128'd0);
    check("rst_rk_valid", 128'(bus.rk_valid), 128'd0);
    check("rst_rk_index", 128'(bus.rk_index), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_err", 128'(bus.err), 128'd0);

    // reset wins over a simultaneous start
    bus.start = 1'b1; bus.key_in = K128;
    tick();
    bus.start = 1'b0;
    rst = 1'b0;
    check("rst_prio_busy", 128'(bus.busy), 128'd0);

    // AES-128, ready held high
    run(2'b00, K128, -1, 1'b0);
    check("lat_first_valid", 128'(lat), 128'd5);
    check("aes128_r0", rk_seen[0], K128[255:128]);
    check("aes128_r1", rk_seen[1], R128_1);
    check("aes128_r2", rk_seen[2], R128_2);
    check("aes128_r3", rk_seen[3], R128_3);
    check("aes128_r10", rk_seen[10], R128_A);
    check("aes128_hs", 128'(hs), 128'd11);
    check("aes128_done", 128'(dn), 128'd1);
    check("aes128_cadence", 128'(rk_cyc[2] - rk_cyc[1]), 128'd4);
    check("aes128_busy_end", 128'(bus.busy), 128'd0);
    check("aes128_valid_end", 128'(bus.rk_valid), 128'd0);

    // AES-256
    run(2'b10, K256, -1, 1'b0);
    check("aes256_r1", rk_seen[1], K256[127:0]);
    check("aes256_w8", 128'(rk_seen[2][127:96]), 128'h9ba35411);
    check("aes256_r14", rk_seen[14], R256_E);
    check("aes256_hs", 128'(hs), 128'd15);
    check("aes256_done", 128'(dn), 128'd1);

    // AES-192 (build option) and the illegal encoding
`ifdef KEY_SCHEDULE_AES192_EN
    run(2'b01, K192, -1, 1'b0);
    check("aes192_r12", rk_seen[12], R192_C);
    check("aes192_hs", 128'(hs), 128'd13);
    check("aes192_done", 128'(dn), 128'd1);
`else
    reject("aes192_off", 2'b01);
`endif
    reject("illegal", 2'b11);

    // backpressure after round 2 appears
    run(2'b00, K128, 2, 1'b0);
    check("bp_r2", rk_seen[2], R128_2);
    check("bp_r3", rk_seen[3], R128_3);
    check("bp_r10", rk_seen[10], R128_A);
    check("bp_hs", 128'(hs), 128'd11);

    // start while busy is ignored
    run(2'b00, K128, -1, 1'b1);
    check("poke_r1", rk_seen[1], R128_1);
    check("poke_r10", rk_seen[10], R128_A);
    check("poke_hs", 128'(hs), 128'd11);
    check("poke_done", 128'(dn), 128'd1);

    // reset during round 5, then a fresh expansion
    begin
      bit reached;
      reached = 1'b0;
      bus.key_len = 2'b00; bus.key_in = K128; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (bus.rk_valid && bus.rk_index == 4'd5) begin
          reached = 1'b1;
          break;
        end
        tick();
      end
      check("mid_reached_r5", 128'(reached), 128'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_round_key", bus.round_key, 128'd0);
      check("mid_rst_valid", 128'(bus.rk_valid), 128'd0);
      check("mid_rst_index", 128'(bus.rk_index), 128'd0);
      check("mid_rst_busy", 128'(bus.busy), 128'd0);
    end
    run(2'b00, K128, -1, 1'b0);
    check("post_rst_r0", rk_seen[0], K128[255:128]);
    check("post_rst_r10", rk_seen[10], R128_A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
